uart_rx_core: RTL
=================

Name: uart_rx_core

Overview:
- Serial UART receiver for the Patmos I/O subsystem.
- Samples the asynchronous rx line at mid-bit, assembles 8N1 frames LSB-first, and presents each byte to the CPU-side I/O device through a 1-entry valid/ready buffer.
- Flags framing errors and overruns.
- Default timing is 80 MHz core clock and 115200 baud, which gives an 8681 ns bit period.

Parameters:
- CLK_FREQ, 80000000, core clock frequency in Hz.
- BAUD_RATE, 115200, line bit rate.
- DATA_BITS, 8, data bits per frame. Supported range is 5..8; the frame has no parity and 1 stop bit.
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (integer, =694), clocks per bit. Derived; do not override.

Ports:
- clk, in, 1, core clock.
- reset, in, 1, asynchronous active-low reset (0 = reset asserted).
- rx, in, 1, serial input. Asynchronous to clk; idles high.
- rd_data, out, DATA_BITS, received byte. Stable while rd_valid=1.
- rd_valid, out, 1, buffer holds an unread byte.
- rd_ready, in, 1, consumer accepts the byte in this cycle when rd_valid=1.
- frame_err, out, 1, one-cycle pulse when the stop bit is sampled low.
- overrun, out, 1, one-cycle pulse when a good frame arrives while the buffer is full.
- busy, out, 1, high whenever the FSM is not in IDLE.

Behaviour:
- Reset values (reset=0, asynchronous):
  - The synchronizer flops are set to 1.
  - State goes to IDLE; counters and shift register clear to 0.
  - rd_data=0, rd_valid=0, frame_err=0, overrun=0, busy=0.
  - Reset mid-frame discards the partial frame. A held byte is lost.
- Input path:
  - rx passes through 2 flops to give rx_s. There is no other filtering.
  - All decisions use rx_s only.
- Bit counter:
  - clog2(CLKS_PER_BIT) bits wide; counts down.
  - The FSM acts in the cycle the count equals 0.
- State IDLE:
  - On rx_s=0, load count=CLKS_PER_BIT/2-1 and go to START.
- State START (mid-start-bit check):
  - At count 0 with rx_s=0: load count=CLKS_PER_BIT-1, set bit_idx=0, go to DATA.
  - At count 0 with rx_s=1: treat as a glitch and return to IDLE with no flags.
- State DATA:
  - At count 0: shift rx_s into the MSB of the shift register, shifting right. The first data bit ends up in rd_data[0].
  - Reload the count.
  - If bit_idx=DATA_BITS-1, go to STOP; else increment bit_idx.
- State STOP:
  - At count 0 with rx_s=1 (good frame):
    - Buffer empty, or rd_ready=1 in the same cycle: rd_data is loaded with the shift register and rd_valid=1 from the next cycle.
    - Otherwise: pulse overrun, drop the new byte, and keep the old rd_data.
    - Go to IDLE.
  - At count 0 with rx_s=0: pulse frame_err, discard the byte, go to BREAK.
- State BREAK:
  - Wait for rx_s=1, then go to IDLE. This avoids re-triggering on a held-low line.
- Return to IDLE happens at mid-stop-bit, so a next start edge arriving 0.5 bit later is caught.
- Buffer handshake:
  - A transfer occurs when rd_valid & rd_ready.
  - rd_valid clears on the next cycle unless a new byte loads in that same cycle.
  - A simultaneous load and transfer keeps rd_valid=1 with the new data and no overrun.
  - rd_ready while rd_valid=0 is ignored.
- Latency:
  - rd_valid rises 2 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT + 1 cycles after the rx falling edge of the start bit. With defaults this is 6596 cycles (≈82.45 µs).
- Tolerance: sampling at mid-bit tolerates roughly ±4% baud mismatch across a frame.

Test Plan:
- Reset held 100 ns, then rx idle high for 1000 ns:
  - rd_valid=0, busy=0, no flags.
- Frame 0,0,1,0,1,0,1,0,1,1 (start, d0..d7, stop), each bit 8681 ns, rd_ready=0:
  - rd_data=0xAA and rd_valid=1 at the mid-stop point + 1 cycle.
  - The byte holds until rd_ready=1 for one cycle, after which rd_valid=0.
- Two back-to-back frames 0x55 then 0xAA with rd_ready held 0:
  - First byte 0x55 is retained.
  - overrun pulses exactly one cycle at the second stop sample; rd_data remains 0x55.
- Same two frames with rd_ready=1 asserted in the cycle the second byte loads:
  - No overrun; rd_data=0xAA and rd_valid stays 1.
- Frame 0x3C with the stop bit driven 0, then line held low for 3 bit times, then high:
  - frame_err pulses once; no rd_valid.
  - busy stays high until rx returns high, then the next 0x3C frame is received correctly.
- Other stimuli and their required responses:
  - rx low pulse of 2000 ns (below half-bit): return to IDLE with no flags and no data.
  - reset=0 asserted mid-DATA of a frame: all outputs are 0 immediately.
  - After reset releases, the following full frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_core.sv
// uart_rx_core
// 8N1 UART receiver. It synchronises the asynchronous rx line, samples each bit
// at its midpoint and assembles the frame LSB-first. Each received byte goes
// into a one-entry valid/ready buffer for the CPU-side I/O device. Framing
// errors and overruns are reported as one-cycle pulses.

module uart_rx_core #(
    parameter int CLK_FREQ  = 80000000,
    parameter int BAUD_RATE = 115200,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    // Clocks per bit is derived from the clock and baud rate and is not a
    // free parameter.
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = $clog2(DATA_BITS);

    // The half-bit load moves sampling from the start edge to mid-bit. The
    // full-bit load then steps from one mid-bit point to the next.
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t               state;
    state_t               state_n;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_n;
    logic [IDX_W-1:0]     bit_idx;
    logic [IDX_W-1:0]     bit_idx_n;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_n;
    logic                 rx_meta;
    logic                 rx_s;
    logic                 load_buf;
    logic                 overrun_n;
    logic                 frame_err_n;
    logic                 transfer;

    // Two-flop synchroniser. It resets to the idle-high line level, so a
    // reset does not produce a false start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    assign transfer = rd_valid & rd_ready;
    assign busy     = (state != ST_IDLE);

    // Receiver state, bit timer, bit index and shift register. A reset
    // discards any partial frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            shift_reg <= shift_n;
        end
    end

    // Next-state logic. The timer counts down, and the FSM acts only in the
    // cycle where the timer reads zero.
    always_comb begin
        state_n     = state;
        cnt_n       = (cnt != '0) ? cnt - 1'b1 : cnt;
        bit_idx_n   = bit_idx;
        shift_n     = shift_reg;
        load_buf    = 1'b0;
        overrun_n   = 1'b0;
        frame_err_n = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    cnt_n   = HALF_LOAD;
                    state_n = ST_START;
                end
            end

            ST_START: begin
                if (cnt == '0) begin
                    if (!rx_s) begin
                        cnt_n     = FULL_LOAD;
                        bit_idx_n = '0;
                        state_n   = ST_DATA;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end

            ST_DATA: begin
                if (cnt == '0) begin
                    shift_n = {rx_s, shift_reg[DATA_BITS-1:1]};
                    cnt_n   = FULL_LOAD;
                    if (bit_idx == LAST_IDX) begin
                        state_n = ST_STOP;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end
            end

            ST_STOP: begin
                if (cnt == '0) begin
                    if (rx_s) begin
                        if (!rd_valid || rd_ready) begin
                            load_buf = 1'b1;
                        end else begin
                            overrun_n = 1'b1;
                        end
                        state_n = ST_IDLE;
                    end else begin
                        frame_err_n = 1'b1;
                        state_n     = ST_BREAK;
                    end
                end
            end

            ST_BREAK: begin
                if (rx_s) begin
                    state_n = ST_IDLE;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // One-entry output buffer. A load takes priority over a transfer in the
    // same cycle, so rd_valid stays high and carries the new byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (load_buf) begin
            rd_data  <= shift_reg;
            rd_valid <= 1'b1;
        end else if (transfer) begin
            rd_valid <= 1'b0;
        end
    end

    // Registered error pulses. Each pulse lasts exactly one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= frame_err_n;
            overrun   <= overrun_n;
        end
    end

endmodule
